// File: rtl/u2sm_conv_arbiter.sv
// Round-robin shared U2 -> sign-magnitude converter with a tagged valid/ready
// response channel and a saturating overflow-error counter.
module u2sm_conv_arbiter #(
    parameter int unsigned N     = 8,
    parameter int unsigned NREQ  = 2,
    parameter int unsigned CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*N-1:0]       req_data,
    output logic [NREQ-1:0]         gnt,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic [N-1:0]            rsp_data,
    output logic                    rsp_error,
    output logic                    busy,
    output logic [CNT_W-1:0]        err_cnt,
    input  logic                    err_clr
);

    localparam int unsigned      ID_W    = $clog2(NREQ);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONV,
        S_RESP
    } state_t;

    state_t            r_state;
    logic [ID_W-1:0]   r_rr_ptr;
    logic [ID_W-1:0]   r_id;
    logic [N-1:0]      r_op;
    logic              r_rsp_valid;
    logic [ID_W-1:0]   r_rsp_id;
    logic [N-1:0]      r_rsp_data;
    logic              r_rsp_error;
    logic              r_busy;
    logic [CNT_W-1:0]  r_err_cnt;

    logic [NREQ-1:0]   w_gnt;
    logic [ID_W-1:0]   w_win;
    logic [ID_W-1:0]   w_idx;
    logic              w_found;
    int unsigned       w_k;
    logic [N-1:0]      w_mag;
    logic [N-1:0]      w_res;
    logic              w_err;

    // Cyclic first-set search starting at rr_ptr; only grants while idle.
    always_comb begin
        w_gnt   = '0;
        w_win   = '0;
        w_idx   = '0;
        w_found = 1'b0;
        w_k     = 0;
        if (r_state == S_IDLE && !rst) begin
            for (int i = 0; i < int'(NREQ); i++) begin
                w_k   = (32'(r_rr_ptr) + 32'(i)) % NREQ;
                w_idx = ID_W'(w_k);
                if (!w_found && req[w_idx]) begin
                    w_found      = 1'b1;
                    w_win        = w_idx;
                    w_gnt[w_idx] = 1'b1;
                end
            end
        end
    end

    // Negative values negate their magnitude; only the most negative value overflows.
    always_comb begin
        w_mag = {1'b1, ~r_op[N-2:0]} + N'(1);
        w_res = r_op[N-1] ? w_mag : r_op;
        w_err = r_op[N-1] & ~w_mag[N-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= '0;
            r_id        <= '0;
            r_op        <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_data  <= '0;
            r_rsp_error <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_op     <= req_data[32'(w_win)*N +: N];
                        r_id     <= w_win;
                        r_rr_ptr <= (w_win == ID_W'(NREQ - 1)) ? '0 : w_win + ID_W'(1);
                        r_busy   <= 1'b1;
                        r_state  <= S_CONV;
                    end
                end
                S_CONV: begin
                    r_rsp_data  <= w_res;
                    r_rsp_error <= w_err;
                    r_rsp_id    <= r_id;
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    // Clear wins over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst || err_clr) begin
            r_err_cnt <= '0;
        end else if (r_state == S_CONV && w_err && r_err_cnt != CNT_MAX) begin
            r_err_cnt <= r_err_cnt + CNT_W'(1);
        end
    end

    assign gnt       = w_gnt;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_data  = r_rsp_data;
    assign rsp_error = r_rsp_error;
    assign busy      = r_busy;
    assign err_cnt   = r_err_cnt;

endmodule
